// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline stage: load formatting, result select, 2-entry skid buffer with flush.
// Define MEM_WB_PERF_CNT_EN to add stall/flush performance counters.
module mem_wb_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               sys_clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [XLEN-1:0]    dm_rd_data_i,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic [2:0]         funct3_i,
  input  logic               reg_write_i,
  input  logic               mem_to_reg_i,
  input  logic [RADDR_W-1:0] rd_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    wb_data_o,
  output logic               reg_write_o,
  output logic [RADDR_W-1:0] rd_o,
  output logic               misalign_o
`ifdef MEM_WB_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] off_half;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [31:0]      ld_word;
  logic [XLEN-1:0]  word_sext;
  logic [XLEN-1:0]  word_zext;
  logic [XLEN-1:0]  ld_val;
  logic             ld_mis;
  logic [XLEN-1:0]  in_data;
  logic             in_mis;

  assign off      = alu_result_i[OFF_W-1:0];
  assign off_half = {off[OFF_W-1:1], 1'b0};
  assign ld_byte  = dm_rd_data_i[{off, 3'b000} +: 8];
  assign ld_half  = dm_rd_data_i[{off_half, 3'b000} +: 16];

  generate
    if (XLEN == 64) begin : g_word64
      assign ld_word   = off[OFF_W-1] ? dm_rd_data_i[XLEN-1 -: 32] : dm_rd_data_i[31:0];
      assign word_sext = {{(XLEN-32){ld_word[31]}}, ld_word};
      assign word_zext = {{(XLEN-32){1'b0}}, ld_word};
    end else begin : g_word32
      assign ld_word   = dm_rd_data_i[31:0];
      assign word_sext = ld_word;
      assign word_zext = ld_word;
    end
  endgenerate

  // Misaligned accesses still use the lane selected by the truncated aligned offset.
  always_comb begin
    ld_val = dm_rd_data_i;
    ld_mis = 1'b0;
    case (funct3_i)
      3'b000: ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_mis = off[0];
      end
      3'b101: begin
        ld_val = {{(XLEN-16){1'b0}}, ld_half};
        ld_mis = off[0];
      end
      3'b010: begin
        ld_val = word_sext;
        ld_mis = |off[1:0];
      end
      3'b110: begin
        if (XLEN == 64) begin
          ld_val = word_zext;
          ld_mis = |off[1:0];
        end
      end
      3'b011: begin
        if (XLEN == 64) ld_mis = |off;
      end
      default: ld_val = dm_rd_data_i;
    endcase
  end

  assign in_data = mem_to_reg_i ? ld_val : alu_result_i;
  assign in_mis  = mem_to_reg_i & ld_mis;

  logic               m_valid_q, m_valid_d;
  logic [XLEN-1:0]    m_data_q, m_data_d;
  logic               m_rw_q, m_rw_d;
  logic [RADDR_W-1:0] m_rd_q, m_rd_d;
  logic               m_mis_q, m_mis_d;
  logic               s_valid_q, s_valid_d;
  logic [XLEN-1:0]    s_data_q, s_data_d;
  logic               s_rw_q, s_rw_d;
  logic [RADDR_W-1:0] s_rd_q, s_rd_d;
  logic               s_mis_q, s_mis_d;
  logic               accept;
  logic               consume;

  // Ready depends only on registered skid state, never on out_ready_i.
  assign in_ready_o = ~s_valid_q & ~rst_i;
  assign accept     = in_valid_i & in_ready_o;
  assign consume    = m_valid_q & out_ready_i;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_rw_d    = m_rw_q;
    m_rd_d    = m_rd_q;
    m_mis_d   = m_mis_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_rw_d    = s_rw_q;
    s_rd_d    = s_rd_q;
    s_mis_d   = s_mis_q;
    if (flush_i) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (consume && s_valid_q) begin
      m_valid_d = 1'b1;
      m_data_d  = s_data_q;
      m_rw_d    = s_rw_q;
      m_rd_d    = s_rd_q;
      m_mis_d   = s_mis_q;
      s_valid_d = 1'b0;
    end else if (consume || !m_valid_q) begin
      m_valid_d = accept;
      if (accept) begin
        m_data_d = in_data;
        m_rw_d   = reg_write_i;
        m_rd_d   = rd_i;
        m_mis_d  = in_mis;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
      s_rw_d    = reg_write_i;
      s_rd_d    = rd_i;
      s_mis_d   = in_mis;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_rw_q    <= 1'b0;
      m_rd_q    <= '0;
      m_mis_q   <= 1'b0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      s_rw_q    <= 1'b0;
      s_rd_q    <= '0;
      s_mis_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_rw_q    <= m_rw_d;
      m_rd_q    <= m_rd_d;
      m_mis_q   <= m_mis_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_rw_q    <= s_rw_d;
      s_rd_q    <= s_rd_d;
      s_mis_q   <= s_mis_d;
    end
  end

  assign out_valid_o = m_valid_q;
  assign wb_data_o   = m_data_q;
  assign rd_o        = m_rd_q;
  assign reg_write_o = m_rw_q & m_valid_q & (m_rd_q != '0);
  assign misalign_o  = m_mis_q & m_valid_q;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // A flush counts when it kills a held entry or an offered one.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'b0, m_valid_q & ~out_ready_i};
    flush_cnt_d = flush_cnt_q + {31'b0, flush_i & (m_valid_q | s_valid_q | in_valid_i)};
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg (XLEN=32): directed table, corner sequences, random vs queue model.
module tb_mem_wb_pipe_reg;

  logic        clk;
  logic        rst_i, flush_i, in_valid_i, in_ready_o;
  logic [31:0] dm_rd_data_i, alu_result_i;
  logic [2:0]  funct3_i;
  logic        reg_write_i, mem_to_reg_i;
  logic [4:0]  rd_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] wb_data_o;
  logic        reg_write_o;
  logic [4:0]  rd_o;
  logic        misalign_o;
`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
  int unsigned stall_m, flush_m;
`endif

  mem_wb_pipe_reg #(.XLEN(32), .RADDR_W(5)) dut (
    .sys_clk_i    (clk),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .dm_rd_data_i (dm_rd_data_i),
    .alu_result_i (alu_result_i),
    .funct3_i     (funct3_i),
    .reg_write_i  (reg_write_i),
    .mem_to_reg_i (mem_to_reg_i),
    .rd_i         (rd_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .wb_data_o    (wb_data_o),
    .reg_write_o  (reg_write_o),
    .rd_o         (rd_o),
    .misalign_o   (misalign_o)
`ifdef MEM_WB_PERF_CNT_EN
    ,
    .stall_cnt_o  (stall_cnt_o),
    .flush_cnt_o  (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        rw;
    logic [4:0]  rd;
    logic        mis;
  } ent_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] dm;
    logic [31:0] alu;
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] exp_data;
    logic        exp_mis;
    logic        exp_rw;
  } vec_t;

  ent_t mq[$];
  vec_t tbl[13];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference formatting from the load rules, using plain arithmetic on the offset.
  function automatic ent_t mk(input logic [2:0] f3, input logic [31:0] dm, input logic [31:0] alu,
                              input logic m2r, input logic rw, input logic [4:0] rd);
    ent_t e;
    int unsigned off, b, h;
    off   = alu % 4;
    b     = (dm >> (8 * off)) % 256;
    h     = (dm >> (16 * (off / 2))) % 65536;
    e.rw  = rw;
    e.rd  = rd;
    e.mis = 1'b0;
    e.data = alu;
    if (m2r) begin
      case (f3)
        3'd0: e.data = (b >= 128) ? b - 32'd256 : b;
        3'd4: e.data = b;
        3'd1: begin e.data = (h >= 32768) ? h - 32'd65536 : h; e.mis = (off % 2) != 0; end
        3'd5: begin e.data = h; e.mis = (off % 2) != 0; end
        3'd2: begin e.data = dm; e.mis = off != 0; end
        default: e.data = dm;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] dm, input logic [31:0] alu,
                       input logic m2r, input logic rw, input logic [4:0] rd);
    funct3_i     = f3;
    dm_rd_data_i = dm;
    alu_result_i = alu;
    mem_to_reg_i = m2r;
    reg_write_i  = rw;
    rd_i         = rd;
  endtask

  // Advance one clock: update the model from pre-edge inputs, then compare just after the edge.
  task automatic cycle();
    logic acc, cons;
    ent_t exp_e;
    logic exp_v, exp_rdy, exp_rw, exp_mis, bad;
    if (rst_i) begin
      mq.delete();
`ifdef MEM_WB_PERF_CNT_EN
      stall_m = 0;
      flush_m = 0;
`endif
    end else begin
`ifdef MEM_WB_PERF_CNT_EN
      if (mq.size() > 0 && !out_ready_i) stall_m++;
      if (flush_i && (mq.size() > 0 || in_valid_i)) flush_m++;
`endif
      if (flush_i) begin
        mq.delete();
      end else begin
        acc  = in_valid_i && (mq.size() < 2);
        cons = (mq.size() > 0) && out_ready_i;
        if (cons) void'(mq.pop_front());
        if (acc) mq.push_back(mk(funct3_i, dm_rd_data_i, alu_result_i, mem_to_reg_i, reg_write_i, rd_i));
      end
    end
    @(posedge clk);
    #1;
    exp_v   = mq.size() > 0;
    exp_rdy = !rst_i && (mq.size() < 2);
    exp_rw  = 1'b0;
    exp_mis = 1'b0;
    bad     = (out_valid_o !== exp_v) || (in_ready_o !== exp_rdy);
    if (exp_v) begin
      exp_e   = mq[0];
      exp_rw  = exp_e.rw && (exp_e.rd != 5'd0);
      exp_mis = exp_e.mis;
      bad = bad || (wb_data_o !== exp_e.data) || (rd_o !== exp_e.rd);
    end
    bad = bad || (reg_write_o !== exp_rw) || (misalign_o !== exp_mis);
`ifdef MEM_WB_PERF_CNT_EN
    bad = bad || (stall_cnt_o !== stall_m) || (flush_cnt_o !== flush_m);
`endif
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL model t=%0t: valid=%b/%b ready=%b/%b data=0x%08h/0x%08h rd=%0d/%0d rw=%b/%b mis=%b/%b (got/expected)",
               $time, out_valid_o, exp_v, in_ready_o, exp_rdy, wb_data_o, exp_v ? exp_e.data : 32'h0,
               rd_o, exp_v ? exp_e.rd : 5'd0, reg_write_o, exp_rw, misalign_o, exp_mis);
    end
  endtask

  initial begin
    tbl[0]  = '{3'b000, 32'h12F4_5678, 32'h0000_1001, 1'b1, 1'b1, 5'd5,  32'h0000_0056, 1'b0, 1'b1};
    tbl[1]  = '{3'b000, 32'h12F4_8678, 32'h0000_1001, 1'b1, 1'b1, 5'd5,  32'hFFFF_FF86, 1'b0, 1'b1};
    tbl[2]  = '{3'b101, 32'hBEEF_0000, 32'h0000_0002, 1'b1, 1'b1, 5'd6,  32'h0000_BEEF, 1'b0, 1'b1};
    tbl[3]  = '{3'b001, 32'hBEEF_0000, 32'h0000_0001, 1'b1, 1'b1, 5'd7,  32'h0000_0000, 1'b1, 1'b1};
    tbl[4]  = '{3'b010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 1'b1, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0};
    tbl[5]  = '{3'b100, 32'h8000_0000, 32'h0000_0003, 1'b1, 1'b1, 5'd8,  32'h0000_0080, 1'b0, 1'b1};
    tbl[6]  = '{3'b000, 32'h8000_0000, 32'h0000_0003, 1'b1, 1'b1, 5'd8,  32'hFFFF_FF80, 1'b0, 1'b1};
    tbl[7]  = '{3'b001, 32'h8001_0000, 32'h0000_0002, 1'b1, 1'b1, 5'd9,  32'hFFFF_8001, 1'b0, 1'b1};
    tbl[8]  = '{3'b010, 32'hCAFE_BABE, 32'h0000_0000, 1'b1, 1'b1, 5'd10, 32'hCAFE_BABE, 1'b0, 1'b1};
    tbl[9]  = '{3'b010, 32'h1122_3344, 32'h0000_0002, 1'b1, 1'b1, 5'd11, 32'h1122_3344, 1'b1, 1'b1};
    tbl[10] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, 1'b1, 5'd12, 32'h0000_0003, 1'b0, 1'b1};
    tbl[11] = '{3'b101, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b1, 5'd13, 32'h0000_FFFF, 1'b0, 1'b1};
    tbl[12] = '{3'b000, 32'h0000_007F, 32'h0000_0000, 1'b1, 1'b0, 5'd3,  32'h0000_007F, 1'b0, 1'b0};

    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    drive(3'b000, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0);
    cycle();
    cycle();
    chk("reset_out_valid", {31'b0, out_valid_o}, 32'd0);
    chk("reset_wb_data", wb_data_o, 32'd0);
    chk("reset_rd", {27'b0, rd_o}, 32'd0);
    chk("reset_reg_write", {31'b0, reg_write_o}, 32'd0);
    chk("reset_misalign", {31'b0, misalign_o}, 32'd0);
    chk("reset_in_ready_low", {31'b0, in_ready_o}, 32'd0);
    rst_i = 1'b0;
    #1;
    chk("in_ready_after_reset", {31'b0, in_ready_o}, 32'd1);

    // Directed table, back-to-back with the consumer always ready.
    out_ready_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].f3, tbl[i].dm, tbl[i].alu, tbl[i].m2r, tbl[i].rw, tbl[i].rd);
      in_valid_i = 1'b1;
      cycle();
      chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid_o}, 32'd1);
      chk($sformatf("tbl%0d_data", i), wb_data_o, tbl[i].exp_data);
      chk($sformatf("tbl%0d_mis", i), {31'b0, misalign_o}, {31'b0, tbl[i].exp_mis});
      chk($sformatf("tbl%0d_rw", i), {31'b0, reg_write_o}, {31'b0, tbl[i].exp_rw});
      chk($sformatf("tbl%0d_rd", i), {27'b0, rd_o}, {27'b0, tbl[i].rd});
    end
    in_valid_i = 1'b0;
    cycle();

    // Backpressure: A into M, B into S, C refused, then drained in order.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    drive(3'b000, 32'h0, 32'hA, 1'b0, 1'b1, 5'd1);
    cycle();
    chk("bp_A_held", {27'b0, rd_o}, 32'd1);
    drive(3'b000, 32'h0, 32'hB, 1'b0, 1'b1, 5'd2);
    cycle();
    chk("bp_full_ready", {31'b0, in_ready_o}, 32'd0);
    drive(3'b000, 32'h0, 32'hC, 1'b0, 1'b1, 5'd3);
    cycle();
    chk("bp_stable_data", wb_data_o, 32'hA);
    chk("bp_C_refused", {31'b0, in_ready_o}, 32'd0);
    out_ready_i = 1'b1;
    cycle();
    chk("bp_B_out", wb_data_o, 32'hB);
    cycle();
    chk("bp_C_out", wb_data_o, 32'hC);
    in_valid_i = 1'b0;
    cycle();
    chk("bp_drained", {31'b0, out_valid_o}, 32'd0);

    // Flush with M and S full and a new entry offered.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    drive(3'b000, 32'h0, 32'h11, 1'b0, 1'b1, 5'd4);
    cycle();
    drive(3'b000, 32'h0, 32'h22, 1'b0, 1'b1, 5'd5);
    cycle();
    flush_i = 1'b1;
    drive(3'b000, 32'h0, 32'h33, 1'b0, 1'b1, 5'd31);
    cycle();
    chk("flush_valid", {31'b0, out_valid_o}, 32'd0);
    chk("flush_reg_write", {31'b0, reg_write_o}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready_o}, 32'd1);
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    cycle();
    cycle();
    chk("flush_dropped", {31'b0, out_valid_o}, 32'd0);

    // Reset mid-stall with the skid entry occupied.
    out_ready_i = 1'b0;
    in_valid_i  = 1'b1;
    drive(3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 5'd6);
    cycle();
    drive(3'b001, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b1, 5'd7);
    cycle();
    rst_i = 1'b1;
    cycle();
    chk("rst_stall_valid", {31'b0, out_valid_o}, 32'd0);
    chk("rst_stall_data", wb_data_o, 32'd0);
    chk("rst_stall_rd", {27'b0, rd_o}, 32'd0);
    chk("rst_stall_mis", {31'b0, misalign_o}, 32'd0);
    rst_i = 1'b0; in_valid_i = 1'b0;

`ifdef MEM_WB_PERF_CNT_EN
    in_valid_i = 1'b1;
    drive(3'b000, 32'h0, 32'h5, 1'b0, 1'b1, 5'd8);
    cycle();
    in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("stall_cnt_4", stall_cnt_o, 32'd4);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    chk("stall_cnt_reset", stall_cnt_o, 32'd0);
`endif

    // Randomized traffic checked cycle by cycle against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic [2:0] f3;
      case ($urandom_range(0, 4))
        0: f3 = 3'b000;
        1: f3 = 3'b001;
        2: f3 = 3'b010;
        3: f3 = 3'b100;
        default: f3 = 3'b101;
      endcase
      drive(f3, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)));
      in_valid_i  = ($urandom_range(0, 99) < 70);
      out_ready_i = ($urandom_range(0, 99) < 60);
      flush_i     = ($urandom_range(0, 99) < 4);
      rst_i       = ($urandom_range(0, 99) < 2);
      cycle();
    end
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
